// File: rtl/stopwatch_counter_pkg.sv
// Shared types and constants for the stopwatch_counter block.
//   sw_state_e : control FSM states (stop / run / one-cycle clear)
//   SEC_MAX, MIN_MAX : last value of each time field before it wraps
//   CNT_W : width of the decimal MMSS display value
//   to_cnt() : packs minutes/seconds into min*100 + sec
package stopwatch_counter_pkg;

  typedef enum logic [1:0] {
    StStop,
    StRun,
    StClear
  } sw_state_e;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned CNT_W   = 14;
  localparam int unsigned FIELD_W = 6;

  function automatic logic [CNT_W-1:0] to_cnt(input logic [FIELD_W-1:0] min_v,
                                               input logic [FIELD_W-1:0] sec_v);
    return CNT_W'(min_v) * CNT_W'(100) + CNT_W'(sec_v);
  endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control/status bundle between the button stage, the stopwatch and the FND path.
//   i_run_stop, i_clear, i_inc_min, i_inc_sec : single-cycle control pulses
//   o_cnt     : minutes*100 + seconds
//   o_running : high while the stopwatch runs
// Modports: master drives the pulses, slave (the stopwatch) drives the status.
interface stopwatch_counter_if;
  import stopwatch_counter_pkg::*;

  logic             i_run_stop;
  logic             i_clear;
  logic             i_inc_min;
  logic             i_inc_sec;
  logic [CNT_W-1:0] o_cnt;
  logic             o_running;

  modport master (
    output i_run_stop, i_clear, i_inc_min, i_inc_sec,
    input  o_cnt, o_running
  );

  modport slave (
    input  i_run_stop, i_clear, i_inc_min, i_inc_sec,
    output o_cnt, o_running
  );

endinterface

// File: rtl/stopwatch_counter_tick_gen.sv
// One-second tick divider for the stopwatch.
//   clk, rst : clock, asynchronous active-high reset
//   en       : count enable; the count holds while low
//   clr      : synchronous clear, overrides en
//   tick     : one-cycle pulse in the cycle the count wraps TICK_DIV-1 -> 0
module stopwatch_counter_tick_gen #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DivW = $clog2(TICK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);

  logic [DivW-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q;
    tick  = 1'b0;
    if (clr) begin
      div_d = '0;
    end else if (en) begin
      if (div_q == DivLast) begin
        div_d = '0;
        tick  = 1'b1;
      end else begin
        div_d = div_q + DivW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch (00:00..59:59) driving the FND count input.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : stopwatch_counter_if.slave (control pulses in, o_cnt/o_running out)
// Parameter TICK_DIV : clk cycles per one-second tick (>= 2).
// Build option STOPWATCH_SETTIME_EN: when defined, i_inc_sec/i_inc_min step the
// fields while stopped; otherwise those inputs are ignored.
module stopwatch_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic                clk,
  input  logic                rst,
  stopwatch_counter_if.slave  bus
);

  localparam logic [FIELD_W-1:0] SecLast = FIELD_W'(SEC_MAX);
  localparam logic [FIELD_W-1:0] MinLast = FIELD_W'(MIN_MAX);

  sw_state_e          state_q, state_d;
  logic               running_q;
  logic [FIELD_W-1:0] sec_q, sec_d;
  logic [FIELD_W-1:0] min_q, min_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               tick;

  stopwatch_counter_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == StRun),
    .clr  (state_q == StClear),
    .tick (tick)
  );

  // Clear beats run/stop in STOP; RUN ignores clear.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStop: begin
        if (bus.i_clear) begin
          state_d = StClear;
        end else if (bus.i_run_stop) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (bus.i_run_stop) begin
          state_d = StStop;
        end
      end
      StClear: state_d = StStop;
      default: state_d = StStop;
    endcase
  end

  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    if (state_q == StClear) begin
      sec_d = '0;
      min_d = '0;
    end else if (tick) begin
      if (sec_q == SecLast) begin
        sec_d = '0;
        min_d = (min_q == MinLast) ? '0 : min_q + FIELD_W'(1);
      end else begin
        sec_d = sec_q + FIELD_W'(1);
      end
    end
`ifdef STOPWATCH_SETTIME_EN
    // Manual set: independent wrap per field, dropped if a control pulse is present.
    else if (state_q == StStop && !bus.i_clear && !bus.i_run_stop) begin
      if (bus.i_inc_sec) begin
        sec_d = (sec_q == SecLast) ? '0 : sec_q + FIELD_W'(1);
      end
      if (bus.i_inc_min) begin
        min_d = (min_q == MinLast) ? '0 : min_q + FIELD_W'(1);
      end
    end
`endif
  end

`ifndef STOPWATCH_SETTIME_EN
  logic unused_inc;
  assign unused_inc = ^{bus.i_inc_min, bus.i_inc_sec};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StStop;
      running_q <= 1'b0;
      sec_q     <= '0;
      min_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == StRun);
      sec_q     <= sec_d;
      min_q     <= min_d;
      cnt_q     <= to_cnt(min_q, sec_q);
    end
  end

  assign bus.o_cnt     = cnt_q;
  assign bus.o_running = running_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
module tb_stopwatch_counter;
  import stopwatch_counter_pkg::*;

  localparam int unsigned TickDiv = 4;
`ifdef STOPWATCH_SETTIME_EN
  localparam bit SetTime = 1'b1;
`else
  localparam bit SetTime = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  stopwatch_counter_if bus ();

  stopwatch_counter #(
    .TICK_DIV (TickDiv)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: elapsed time as total seconds, divider phase as an integer.
  int m_secs;
  int m_phase;
  bit m_running;
  bit m_clear_pend;
  int m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_secs       = 0;
    m_phase      = 0;
    m_running    = 1'b0;
    m_clear_pend = 1'b0;
    m_cnt        = 0;
  endtask

  task automatic model_edge(input bit rs, input bit clr, input bit im, input bit is);
    int s;
    int m;
    // Display register shows the time held before this edge.
    m_cnt = (m_secs / 60) * 100 + (m_secs % 60);
    if (m_clear_pend) begin
      m_secs       = 0;
      m_phase      = 0;
      m_clear_pend = 1'b0;
    end else if (m_running) begin
      m_phase++;
      if (m_phase == TickDiv) begin
        m_phase = 0;
        m_secs  = (m_secs + 1) % 3600;
      end
      if (rs) m_running = 1'b0;
    end else if (clr) begin
      m_clear_pend = 1'b1;
    end else if (rs) begin
      m_running = 1'b1;
    end else if (SetTime) begin
      m = m_secs / 60;
      s = m_secs % 60;
      if (is) s = (s + 1) % 60;
      if (im) m = (m + 1) % 60;
      m_secs = m * 60 + s;
    end
  endtask

  task automatic step(input bit rs, input bit clr, input bit im, input bit is);
    bus.i_run_stop = rs;
    bus.i_clear    = clr;
    bus.i_inc_min  = im;
    bus.i_inc_sec  = is;
    @(posedge clk);
    model_edge(rs, clr, im, is);
    #1;
    check_eq("o_cnt", bus.o_cnt, m_cnt);
    check_eq("o_running", bus.o_running, m_running);
    bus.i_run_stop = 1'b0;
    bus.i_clear    = 1'b0;
    bus.i_inc_min  = 1'b0;
    bus.i_inc_sec  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int guard;
    int n;
    int held;

    bus.i_run_stop = 1'b0;
    bus.i_clear    = 1'b0;
    bus.i_inc_min  = 1'b0;
    bus.i_inc_sec  = 1'b0;
    model_reset();

    // Reset held, then released.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cnt", bus.o_cnt, 0);
    check_eq("rst_running", bus.o_running, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(100);
    check_eq("idle_cnt", bus.o_cnt, 0);

    // Run for 60 ticks: 01:00 one cycle after the 60th tick.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(241);
    check_eq("one_minute", bus.o_cnt, 100);
    check_eq("one_minute_run", bus.o_running, 1);

    // Stop with the divider two cycles into a period, then resume.
    guard = 0;
    while (m_phase != 1 && guard < 10) begin
      idle(1);
      guard++;
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    held = m_cnt;
    idle(50);
    check_eq("hold_stopped", bus.o_cnt, held);
    check_eq("hold_not_running", bus.o_running, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (bus.o_cnt == held && n < 10) begin
      idle(1);
      n++;
    end
    // Tick 2 cycles after restart, display one cycle later.
    check_eq("restart_latency", n, 3);

    // Clear ignored while running.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    check_eq("clear_in_run", bus.o_running, 1);
    // Stop, then clear: zero two cycles after the pulse.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    check_eq("clear_cnt", bus.o_cnt, 0);
    // Run/stop and clear together in STOP: clear wins.
    idle(1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    check_eq("both_running", bus.o_running, 0);
    check_eq("both_cnt", bus.o_cnt, 0);

`ifdef STOPWATCH_SETTIME_EN
    repeat (59) step(1'b0, 1'b0, 1'b1, 1'b1);
    idle(1);
    check_eq("set_5959", bus.o_cnt, 5959);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    check_eq("wrap_0000", bus.o_cnt, 0);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
`endif

    // Random pulses against the model.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    // Zero, run to 00:37, then an asynchronous reset between edges.
    if (m_running) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    guard = 0;
    while (m_cnt != 37 && guard < 400) begin
      idle(1);
      guard++;
    end
    check_eq("reach_37", bus.o_cnt, 37);
    #1;
    rst = 1'b1;
    #1;
    check_eq("async_rst_cnt", bus.o_cnt, 0);
    check_eq("async_rst_running", bus.o_running, 0);
    model_reset();
    #1;
    rst = 1'b0;
    @(negedge clk);
    idle(20);
    check_eq("after_rst_cnt", bus.o_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
